// File: rtl/candy_wb_arbiter_pkg.sv
// Shared widths, constants and bundle types for the
// candy register-file write-port controller.
package candy_wb_arbiter_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;
    localparam int RegNum     = 32;

    localparam logic              RstEnable   = 1'b1;
    localparam logic              WriteEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord    = '0;

    localparam logic RrReq0 = 1'b0;
    localparam logic RrReq1 = 1'b1;

    typedef struct packed {
        logic [RegAddrBus-1:0] addr;
        logic [RegBus-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/candy_scoreboard.sv
// Pending-write scoreboard: one busy bit per register,
// set by decode claims, cleared by register-file commits.
module candy_scoreboard
    import candy_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  claim_en,
    input  logic [RegAddrBus-1:0] claim_addr,
    input  logic                  clr_en,
    input  logic [RegAddrBus-1:0] clr_addr,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  claim_err
);

    logic [RegNum-1:0] busy;
    logic [RegNum-1:0] set_vec;
    logic [RegNum-1:0] clr_vec;
    logic              dup;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (claim_en) set_vec[claim_addr] = 1'b1;
        if (clr_en)   clr_vec[clr_addr]   = 1'b1;
        set_vec[0] = 1'b0;
    end

    // a busy register retiring this very cycle may be reclaimed
    assign dup = set_vec[claim_addr] & busy[claim_addr] &
                 ~clr_vec[claim_addr];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            busy      <= '0;
            claim_err <= 1'b0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
            if (dup) claim_err <= 1'b1;
        end
    end

    assign busy1 = busy[raddr1];
    assign busy2 = busy[raddr2];

endmodule

// File: rtl/candy_wb_arbiter.sv
// Round-robin arbiter for the single register-file write
// port, with registered write outputs and hazard scoreboard.
module candy_wb_arbiter
    import candy_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb0_valid,
    input  logic [RegAddrBus-1:0] wb0_addr,
    input  logic [RegBus-1:0]     wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [RegAddrBus-1:0] wb1_addr,
    input  logic [RegBus-1:0]     wb1_data,
    output logic                  wb1_ready,
    input  logic                  claim_en,
    input  logic [RegAddrBus-1:0] claim_addr,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  claim_err,
    output logic                  we,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegBus-1:0]     wdata
);

    logic    rr;
    logic    gnt0;
    logic    gnt1;
    logic    xfer;
    wb_req_t req;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst != RstEnable) begin
            unique case (1'b1)
                wb0_valid && wb1_valid: begin
                    gnt0 = (rr == RrReq0);
                    gnt1 = (rr == RrReq1);
                end
                wb0_valid && !wb1_valid: gnt0 = 1'b1;
                !wb0_valid && wb1_valid: gnt1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign xfer      = gnt0 | gnt1;
    assign req       = gnt1 ? '{wb1_addr, wb1_data}
                            : '{wb0_addr, wb0_data};

    // r0 writes complete the handshake but never reach the file
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rr    <= RrReq0;
            we    <= ~WriteEnable;
            waddr <= '0;
            wdata <= ZeroWord;
        end else begin
            we <= (xfer && req.addr != '0) ? WriteEnable
                                           : ~WriteEnable;
            if (xfer) begin
                waddr <= req.addr;
                wdata <= req.data;
                rr    <= gnt0 ? RrReq1 : RrReq0;
            end
        end
    end

    candy_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .clr_en     (we),
        .clr_addr   (waddr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .claim_err  (claim_err)
    );

endmodule

// File: tb/tb_candy_wb_arbiter.sv
// Bench for candy_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model.
module tb_candy_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        claim_en;
    logic [4:0]  claim_addr, raddr1, raddr2;
    logic        busy1, busy2, claim_err;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    bit        m_rr;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit        m_busy [32];
    bit        m_err;
    bit        acc0, acc1;

    always #5 clk = ~clk;

    candy_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .wb0_valid  (wb0_valid),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb0_ready  (wb0_ready),
        .wb1_valid  (wb1_valid),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .wb1_ready  (wb1_ready),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .claim_err  (claim_err),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_we = 0;
        m_waddr = 0;
        m_wdata = 0;
        m_err = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    // compare against the model, then advance it one edge
    task automatic tick();
        bit e0, e1;
        bit nb [32];
        e0 = 0;
        e1 = 0;
        if (!rst) begin
            if (wb0_valid && wb1_valid) begin
                e0 = (m_rr == 0);
                e1 = (m_rr == 1);
            end else begin
                e0 = wb0_valid;
                e1 = wb1_valid;
            end
        end
        chk("wb0_ready", 32'(wb0_ready), 32'(e0));
        chk("wb1_ready", 32'(wb1_ready), 32'(e1));
        chk("we", 32'(we), 32'(m_we));
        chk("waddr", 32'(waddr), 32'(m_waddr));
        chk("wdata", wdata, m_wdata);
        chk("busy1", 32'(busy1), 32'(m_busy[raddr1]));
        chk("busy2", 32'(busy2), 32'(m_busy[raddr2]));
        chk("claim_err", 32'(claim_err), 32'(m_err));
        @(posedge clk);
        acc0 = e0;
        acc1 = e1;
        if (rst) begin
            model_reset();
        end else begin
            nb = m_busy;
            if (m_we) nb[m_waddr] = 0;
            if (claim_en && claim_addr != 0) begin
                if (m_busy[claim_addr] &&
                    !(m_we && m_waddr == claim_addr))
                    m_err = 1;
                nb[claim_addr] = 1;
            end
            m_busy = nb;
            if (e0 || e1) begin
                m_rr = e0 ? 1'b1 : 1'b0;
                m_waddr = e0 ? wb0_addr : wb1_addr;
                m_wdata = e0 ? wb0_data : wb1_data;
                m_we = (m_waddr != 0);
            end else begin
                m_we = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wb0_valid = 0;
        wb1_valid = 0;
        claim_en = 0;
        #1;
    endtask

    initial begin
        rst = 1;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
        claim_en = 0; claim_addr = 0;
        raddr1 = 0; raddr2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset with both requesters pending
        wb0_valid = 1; wb0_addr = 3; wb0_data = 32'h11;
        wb1_valid = 1; wb1_addr = 5; wb1_data = 32'h22;
        raddr1 = 3; raddr2 = 5;
        #1;
        repeat (2) begin
            chk("rst_ready0", 32'(wb0_ready), 0);
            chk("rst_ready1", 32'(wb1_ready), 0);
            tick();
            #1;
        end
        chk("rst_we", 32'(we), 0);
        chk("rst_err", 32'(claim_err), 0);

        // contention: 0,1,0,1
        rst = 0;
        #1;
        chk("ct0_ready0", 32'(wb0_ready), 1);
        chk("ct0_we", 32'(we), 0);
        tick(); #1;
        chk("ct1_ready1", 32'(wb1_ready), 1);
        chk("ct1_waddr", 32'(waddr), 3);
        chk("ct1_wdata", wdata, 32'h11);
        tick(); #1;
        chk("ct2_ready0", 32'(wb0_ready), 1);
        chk("ct2_we", 32'(we), 1);
        chk("ct2_waddr", 32'(waddr), 5);
        chk("ct2_wdata", wdata, 32'h22);
        tick(); #1;
        chk("ct3_ready1", 32'(wb1_ready), 1);
        chk("ct3_waddr", 32'(waddr), 3);
        tick();
        idle();
        chk("ct4_waddr", 32'(waddr), 5);
        tick();

        // r0 drop
        wb1_valid = 1; wb1_addr = 0; wb1_data = 32'hDEAD;
        #1;
        chk("r0_ready1", 32'(wb1_ready), 1);
        tick();
        idle();
        chk("r0_we", 32'(we), 0);
        tick();

        // scoreboard round trip
        raddr1 = 7; raddr2 = 9;
        claim_en = 1; claim_addr = 7;
        #1;
        tick();
        claim_en = 0;
        wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h77;
        #1;
        chk("sb_busy_set", 32'(busy1), 1);
        tick();
        idle();
        chk("sb_we", 32'(we), 1);
        chk("sb_waddr", 32'(waddr), 7);
        chk("sb_busy_commit", 32'(busy1), 1);
        tick();
        chk("sb_busy_clr", 32'(busy1), 0);

        // claim on top of a retiring write
        claim_en = 1; claim_addr = 7;
        #1;
        tick();
        claim_en = 0;
        wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h78;
        #1;
        tick();
        wb0_valid = 0;
        claim_en = 1; claim_addr = 7;
        #1;
        chk("sc_we", 32'(we), 1);
        tick();
        idle();
        chk("sc_busy", 32'(busy1), 1);
        chk("sc_err", 32'(claim_err), 0);

        // double claim
        claim_en = 1; claim_addr = 9;
        #1;
        tick(); tick();
        idle();
        chk("dc_busy", 32'(busy2), 1);
        chk("dc_err", 32'(claim_err), 1);
        repeat (3) tick();
        chk("dc_err_sticky", 32'(claim_err), 1);
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        chk("dc_err_rst", 32'(claim_err), 0);
        chk("dc_busy_rst", 32'(busy2), 0);

        // randomized run
        acc0 = 1;
        acc1 = 1;
        wb0_valid = 0;
        wb1_valid = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!wb0_valid || acc0) begin
                wb0_valid = ($urandom_range(0, 2) != 0);
                wb0_addr = 5'($urandom_range(0, 15));
                wb0_data = $urandom;
            end
            if (!wb1_valid || acc1) begin
                wb1_valid = ($urandom_range(0, 2) != 0);
                wb1_addr = 5'($urandom_range(0, 15));
                wb1_data = $urandom;
            end
            claim_en = ($urandom_range(0, 3) == 0);
            claim_addr = 5'($urandom_range(0, 15));
            raddr1 = 5'($urandom_range(0, 15));
            raddr2 = 5'($urandom_range(0, 15));
            #1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/candy_wb_arbiter.md
# candy_wb_arbiter

Write-port controller for the `candy_regs` register file. Two writeback sources share the single write port:
- requester 0: ALU pipeline result.
- requester 1: load / multicycle unit result.

The block arbitrates them round-robin over valid/ready handshakes and drives a registered `we/waddr/wdata` into the register file. It also keeps a pending-write scoreboard, so decode can stall on read-after-write hazards against results still in flight.

## Interface
Parameters: none. Widths come from `defines.v` (`RegAddrBus` = 5 bits, `RegBus` = 32 bits, `RegNum` = 32).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- wb0_valid  in  1  requester 0 has a result.
- wb0_addr  in  `RegAddrBus`  requester 0 destination register.
- wb0_data  in  `RegBus`  requester 0 result.
- wb0_ready  out  1  requester 0 accepted this cycle.
- wb1_valid / wb1_addr / wb1_data / wb1_ready  same as above, for requester 1.
- claim_en  in  1  decode issues an instruction that will write `claim_addr`.
- claim_addr  in  `RegAddrBus`  register being claimed.
- raddr1, raddr2  in  `RegAddrBus`  decode read addresses to check.
- busy1, busy2  out  1  the addressed register has a pending write.
- claim_err  out  1  sticky; set when a register that is already busy is claimed.
- we  out  1  register-file write enable (registered).
- waddr  out  `RegAddrBus`  register-file write address (registered).
- wdata  out  `RegBus`  register-file write data (registered).

## Operation
**Arbitration**
- State is a 1-bit round-robin pointer `rr`. It names the requester that wins a tie.
- Both `wb0_valid` and `wb1_valid` high: grant requester `rr`, then `rr` becomes the other requester.
- Exactly one valid: grant it, then `rr` points to the other requester.
- Neither valid: no grant; `rr` holds.
- `wbN_ready` is combinational from the valids and `rr` only. At most one ready is high. Ready is never high without the matching valid.
- A transfer occurs when valid and ready are both high. Requesters hold addr/data stable while valid and not ready.
- There is no backpressure from the register file. A grant is issued every cycle at least one requester is valid.

**Output stage**
- On a transfer: `we` ← 1 if the granted address ≠ 0, else 0. `waddr` and `wdata` ← the granted values.
- A transfer to r0 is accepted and completes its handshake, but it is dropped (`we` = 0).
- With no transfer: `we` ← 0; `waddr` and `wdata` hold their previous values.

**Scoreboard**
- Holds `busy[0:RegNum-1]`; `busy[0]` is permanently 0.
- Set: `claim_en` with `claim_addr` ≠ 0 sets `busy[claim_addr]` at the edge.
- Clear: when the registered `we` is 1, `busy[waddr]` clears at the same edge the register file commits the write.
- Set and clear on the same address in the same cycle: set wins (a new claim on top of a retiring write).
- `claim_en` to an address that is already busy and not being cleared this cycle: `claim_err` ← 1 (sticky until reset). The busy bit stays 1.
- `busy1 = busy[raddr1]` and `busy2 = busy[raddr2]`, combinational. Both are 0 for address 0.
- Because the register file bypasses `wdata` on the commit cycle, a read in that cycle sees `busy` = 1 and decode stalls one cycle. This is conservative and correct.

## Timing
- Reset values: `we` = 0, `waddr` = 0, `wdata` = `ZeroWord`, `rr` = 0, all `busy` = 0, `claim_err` = 0.
- During reset, `wb0_ready` and `wb1_ready` are forced to 0 and claims are ignored.
- Latency: a transfer at edge N produces `we/waddr/wdata` valid during cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle. Each requester gets at least every other slot under contention.
- Reset asserted mid-operation: any in-flight output write is discarded (`we` = 0 next cycle) and all busy bits clear. Decode must flush alongside.

## Structure
- Add to `defines.v`: `RrReq0` = 1'b0 and `RrReq1` = 1'b1. Reuse `WriteEnable`, `ZeroWord`, `RstEnable`, `RegNum`.
- One sub-module: `candy_scoreboard` (busy vector, set/clear/priority, `claim_err`, two query ports). The arbiter and output register stay in the top module.

## Test plan
- **Reset:** hold `rst` high for 2 cycles with both valids high → readies 0, `we` 0, `busy1/2` 0, `claim_err` 0.
- **Contention:** `wb0` (addr 3, 0x11) and `wb1` (addr 5, 0x22) held valid from reset → grants go 0, 1, 0, 1. `we/waddr/wdata` = 1/3/0x11, then 1/5/0x22, alternating, each one cycle after its handshake.
- **r0 drop:** `wb1_valid` with addr 0, data 0xDEAD → `wb1_ready` = 1 and `we` = 0 the next cycle.
- **Scoreboard round-trip:** claim r7, `raddr1` = 7 → `busy1` = 1 from the next cycle. `wb0` writes r7 → `busy1` = 0 the cycle after `we` = 1 with `waddr` = 7.
- **Same-cycle set/clear:** claim r7 in the same cycle that `we` commits r7 → `busy[7]` stays 1 and `claim_err` stays 0.
- **Double claim:** claim r9 twice with no write in between → `claim_err` = 1 and stays 1 until `rst`.
